// File: rtl/frame_sequencer_pkg.sv
// frame_sequencer_pkg: shared timeline constants and FSM encoding.
// Used by the sequencer and the slot-address datapath.
package frame_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RUN  = 2'd2
  } fs_state_e;

  localparam int DEF_SLOT_LEN  = 13;
  localparam int DEF_NUM_SLOTS = 16;

  function automatic int frame_len(
    input int slot_len,
    input int num_slots
  );
    return slot_len * num_slots;
  endfunction

  localparam int DEF_FRAME_LEN =
    frame_len(DEF_SLOT_LEN, DEF_NUM_SLOTS);

endpackage

// File: rtl/frame_sequencer_slot_timer.sv
// frame_sequencer_slot_timer: mod-LEN tick counter within one slot.
// Ports: clk, rst (async high), en (advance), clr (to 0, wins), tc (at LEN-1).
module frame_sequencer_slot_timer #(
  parameter int LEN = 13
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tc
);

  localparam int W = (LEN > 1) ? $clog2(LEN) : 1;
  localparam logic [W-1:0] LAST = W'(LEN - 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc = (cnt_q == LAST);

endmodule

// File: rtl/frame_sequencer.sv
// frame_sequencer: playback timeline (frame count, slot address, slot handshake).
// In: start, stop, repeat_en, tick_en, slot_ack. Out: count, addr, slot_req,
// out_trig, busy, done. All outputs registered; rst async active-high.
module frame_sequencer
  import frame_sequencer_pkg::*;
#(
  parameter int SLOT_LEN  = DEF_SLOT_LEN,
  parameter int NUM_SLOTS = DEF_NUM_SLOTS,
  parameter int CNT_W     = 8,
  parameter int ADDR_W    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic              repeat_en,
  input  logic              tick_en,
  input  logic              slot_ack,
  output logic [CNT_W-1:0]  count,
  output logic [ADDR_W-1:0] addr,
  output logic              slot_req,
  output logic              out_trig,
  output logic              busy,
  output logic              done
);

  if (SLOT_LEN < 2) begin : g_bad_len
    $error("frame_sequencer: SLOT_LEN must be >= 2");
  end
  if (NUM_SLOTS < 1 || NUM_SLOTS > (1 << ADDR_W)) begin : g_bad_slots
    $error("frame_sequencer: NUM_SLOTS out of range for ADDR_W");
  end
  if (frame_len(SLOT_LEN, NUM_SLOTS) > (1 << CNT_W)) begin : g_bad_cnt
    $error("frame_sequencer: frame does not fit in CNT_W");
  end

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_SLOTS - 1);

  fs_state_e         state_q, state_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              req_q, req_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              trig_q, trig_d;
  logic              tmr_en;
  logic              tmr_clr;
  logic              tmr_tc;

  frame_sequencer_slot_timer #(
    .LEN (SLOT_LEN)
  ) u_slot_timer (
    .clk (clk),
    .rst (rst),
    .en  (tmr_en),
    .clr (tmr_clr),
    .tc  (tmr_tc)
  );

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    addr_d  = addr_q;
    req_d   = req_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    tmr_en  = 1'b0;
    tmr_clr = 1'b0;

    if (stop) begin
      state_d = ST_IDLE;
      count_d = '0;
      addr_d  = '0;
      req_d   = 1'b0;
      busy_d  = 1'b0;
      tmr_clr = 1'b1;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_d = ST_REQ;
            count_d = '0;
            addr_d  = '0;
            req_d   = 1'b1;
            busy_d  = 1'b1;
          end
        end
        ST_REQ: begin
          if (slot_ack && req_q) begin
            state_d = ST_RUN;
            req_d   = 1'b0;
          end
        end
        ST_RUN: begin
          if (tick_en) begin
            // timer wraps to 0 by itself at slot end
            tmr_en = 1'b1;
            if (!tmr_tc) begin
              count_d = count_q + CNT_W'(1);
            end else if (addr_q != LAST_ADDR) begin
              count_d = count_q + CNT_W'(1);
              addr_d  = addr_q + ADDR_W'(1);
              state_d = ST_REQ;
              req_d   = 1'b1;
            end else begin
              done_d  = 1'b1;
              count_d = '0;
              addr_d  = '0;
              if (repeat_en) begin
                state_d = ST_REQ;
                req_d   = 1'b1;
              end else begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
              end
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
          count_d = '0;
          addr_d  = '0;
          req_d   = 1'b0;
          busy_d  = 1'b0;
          tmr_clr = 1'b1;
        end
      endcase
    end
  end

  // registered alongside count, so it is high while count first reads 1
  assign trig_d = (count_q == '0) && (count_d == CNT_W'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      addr_q  <= '0;
      req_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      trig_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      addr_q  <= addr_d;
      req_q   <= req_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      trig_q  <= trig_d;
    end
  end

  assign count    = count_q;
  assign addr     = addr_q;
  assign slot_req = req_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign out_trig = trig_q;

endmodule

// File: tb/tb_frame_sequencer.sv
// tb_frame_sequencer: scoreboard bench for frame_sequencer.
// Position-based reference model; expected vectors queued per driven cycle.
module tb_frame_sequencer;

  localparam int SL = 13;
  localparam int NS = 16;

  logic       clk;
  logic       rst;
  logic       start;
  logic       stop;
  logic       repeat_en;
  logic       tick_en;
  logic       slot_ack;
  logic [7:0] count;
  logic [3:0] addr;
  logic       slot_req;
  logic       out_trig;
  logic       busy;
  logic       done;

  frame_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .stop      (stop),
    .repeat_en (repeat_en),
    .tick_en   (tick_en),
    .slot_ack  (slot_ack),
    .count     (count),
    .addr      (addr),
    .slot_req  (slot_req),
    .out_trig  (out_trig),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int ndone = 0;
  int ntrig = 0;

  // model: 0 idle, 1 req, 2 run; pos = position in frame
  int m_st  = 0;
  int m_pos = 0;
  bit m_req = 0;
  bit m_busy = 0;
  bit m_done = 0;
  bit m_trig = 0;

  logic [15:0] sb[$];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] obs_vec();
    return {count, addr, slot_req, busy, done, out_trig};
  endfunction

  function automatic logic [15:0] exp_vec();
    logic [7:0] c;
    logic [3:0] a;
    c = 8'(m_pos);
    a = 4'(m_pos / SL);
    return {c, a, m_req, m_busy, m_done, m_trig};
  endfunction

  task automatic model_reset();
    m_st = 0; m_pos = 0; m_req = 0;
    m_busy = 0; m_done = 0; m_trig = 0;
  endtask

  task automatic model_step(input bit s, input bit p, input bit r,
                            input bit t, input bit a);
    int prev;
    prev = m_pos;
    m_done = 0;
    if (p) begin
      m_st = 0; m_pos = 0; m_req = 0; m_busy = 0;
    end else begin
      case (m_st)
        0: if (s) begin
          m_st = 1; m_pos = 0; m_req = 1; m_busy = 1;
        end
        1: if (a) begin
          m_st = 2; m_req = 0;
        end
        default: if (t) begin
          if (m_pos != SL * NS - 1) begin
            m_pos++;
            if (m_pos % SL == 0) begin
              m_st = 1; m_req = 1;
            end
          end else begin
            m_done = 1; m_pos = 0;
            if (r) begin
              m_st = 1; m_req = 1;
            end else begin
              m_st = 0; m_busy = 0;
            end
          end
        end
      endcase
    end
    m_trig = (prev == 0) && (m_pos == 1);
  endtask

  task automatic cyc(input bit s, input bit p, input bit r,
                     input bit t, input bit a);
    logic [15:0] e;
    start = s; stop = p; repeat_en = r;
    tick_en = t; slot_ack = a;
    model_step(s, p, r, t, a);
    sb.push_back(exp_vec());
    @(posedge clk);
    @(negedge clk);
    e = sb.pop_front();
    chk("cyc", 32'(obs_vec()), 32'(e));
    if (done) ndone++;
    if (out_trig) ntrig++;
    start = 1'b0;
    stop = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int drops;
    rst = 1'b1; start = 0; stop = 0;
    repeat_en = 0; tick_en = 0; slot_ack = 0;
    @(negedge clk);
    chk("rst", 32'(obs_vec()), 32'h0);
    rst = 1'b0;

    // full frame, ack and tick tied high
    ndone = 0;
    cyc(1, 0, 0, 1, 1);
    chk("req0", 32'(slot_req), 32'd1);
    n = 1;
    while (ndone == 0 && n < 300) begin
      cyc(0, 0, 0, 1, 1);
      n++;
    end
    chk("frame_len", 32'(n), 32'd225);
    chk("frame_end", 32'({count, addr, busy}), 32'h0);
    cyc(0, 0, 0, 1, 1);
    chk("done_once", 32'(ndone), 32'd1);

    // delayed ack at slot 3
    cyc(1, 0, 0, 1, 1);
    n = 0;
    while (!(m_st == 1 && m_pos == 39) && n < 100) begin
      cyc(0, 0, 0, 1, 1);
      n++;
    end
    chk("to_slot3", 32'(n < 100), 32'd1);
    for (int i = 0; i < 5; i++) begin
      cyc(0, 0, 0, 1, 0);
      chk("hold_cnt", 32'(count), 32'd39);
      chk("hold_addr", 32'(addr), 32'd3);
      chk("hold_req", 32'(slot_req), 32'd1);
    end
    cyc(0, 0, 0, 1, 1);
    cyc(0, 0, 0, 1, 1);
    chk("resume", 32'(count), 32'd40);
    cyc(0, 1, 0, 1, 1);

    // repeat over three frames
    ndone = 0; ntrig = 0; drops = 0;
    cyc(1, 0, 1, 1, 1);
    n = 0;
    while (ndone < 3 && n < 800) begin
      cyc(0, 0, 1, 1, 1);
      if (!busy) drops++;
      n++;
    end
    chk("rep_done", 32'(ndone), 32'd3);
    chk("rep_trig", 32'(ntrig), 32'd3);
    chk("rep_busy", 32'(drops), 32'd0);
    cyc(0, 1, 0, 1, 1);

    // stop mid-frame at count 100
    ndone = 0;
    cyc(1, 0, 0, 1, 1);
    n = 0;
    while (!(m_st == 2 && m_pos == 100) && n < 200) begin
      cyc(0, 0, 0, 1, 1);
      n++;
    end
    chk("at100", 32'({count, addr}), 32'({8'd100, 4'd7}));
    cyc(0, 1, 0, 1, 1);
    chk("stop_clr", 32'({count, addr, slot_req, busy}), 32'h0);
    chk("stop_done", 32'(ndone), 32'd0);
    cyc(1, 0, 0, 1, 1);
    chk("fresh", 32'({count, slot_req, busy}), 32'({8'd0, 2'b11}));

    // sparse ticks, start while busy
    for (int i = 0; i < 120; i++) begin
      cyc(i == 50, 0, 0, (i % 4) == 3, 1);
    end
    cyc(0, 1, 0, 1, 1);
    cyc(1, 1, 0, 1, 1);
    chk("ss_idle", 32'({slot_req, busy}), 32'd0);

    // async reset mid-run
    cyc(1, 0, 0, 1, 1);
    for (int i = 0; i < 40; i++) cyc(0, 0, 0, 1, 1);
    #2 rst = 1'b1;
    #1 chk("arst", 32'(obs_vec()), 32'h0);
    model_reset();
    sb.delete();
    #1 rst = 1'b0;
    ndone = 0; ntrig = 0;
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 1, 1);
    chk("arst_glitch", 32'(ndone + ntrig), 32'd0);
    chk("arst_idle", 32'(busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
